// File: rtl/input_debouncer_if.sv
// Bundle of the debouncer's data signals: raw synchronized inputs in,
// debounced levels and edge pulses out. clk/reset_n stay plain ports.
interface input_debouncer_if #(
  parameter int DIGITS = 6
);
  logic [DIGITS-1:0] sync_in;
  logic [DIGITS-1:0] level_out;
  logic [DIGITS-1:0] rise_pulse;
  logic [DIGITS-1:0] fall_pulse;

  // Producer of sync_in / consumer of the debounced outputs
  modport master (
    output sync_in,
    input  level_out, rise_pulse, fall_pulse
  );

  // The debouncer itself
  modport slave (
    input  sync_in,
    output level_out, rise_pulse, fall_pulse
  );
endinterface

// File: rtl/input_debouncer.sv
// Per-bit debouncer + edge detector. A level change is accepted on the
// DEBOUNCE_CYCLES-th consecutive edge sampling the new value; level_out and
// the matching one-cycle rise/fall pulse update on that same edge.
// Optional auto-repeat of rise_pulse while a bit is held high is enabled by
// defining DEBOUNCER_AUTOREPEAT_EN.
module input_debouncer #(
  parameter int DIGITS          = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 4096,
  parameter int REPEAT_PERIOD   = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input_debouncer_if.slave  bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [DIGITS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [DIGITS-1:0]         level_q, level_d;
  logic [DIGITS-1:0]         rise_q, rise_d;
  logic [DIGITS-1:0]         fall_q, fall_d;

`ifdef DEBOUNCER_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  // hold_q counts edges since the rise; a pulse fires on the edge where it
  // would reach REPEAT_DELAY, and it reloads so the next hit is PERIOD later.
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [DIGITS-1:0][HW-1:0] hold_q, hold_d;
`endif

  // Next-state: mismatch counting, level acceptance, pulse generation
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
`ifdef DEBOUNCER_AUTOREPEAT_EN
    hold_d  = hold_q;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.sync_in[i] == level_q[i]) begin
        // any matching sample throws away a partial run
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = bus.sync_in[i];
        cnt_d[i]   = '0;
        rise_d[i]  = bus.sync_in[i];
        fall_d[i]  = ~bus.sync_in[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
`ifdef DEBOUNCER_AUTOREPEAT_EN
      // Only count while the bit stays high across this edge; the rise edge
      // itself and an accepted fall both leave the counter cleared.
      if (level_q[i] && level_d[i]) begin
        if (hold_q[i] == HOLD_LAST) begin
          rise_d[i] = 1'b1;
          hold_d[i] = HOLD_RELOAD;
        end else begin
          hold_d[i] = hold_q[i] + HW'(1);
        end
      end else begin
        hold_d[i] = '0;
      end
`endif
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
`ifdef DEBOUNCER_AUTOREPEAT_EN
      hold_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef DEBOUNCER_AUTOREPEAT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed test-plan sequences
// followed by randomized toggling, all compared every cycle against a
// behavioural model (run lengths and time-since-rise arithmetic).
module tb_input_debouncer;
  localparam int DIGITS = 6;
  localparam int DC     = 4;
  localparam int RD     = 20;
  localparam int RP     = 8;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;
  int   cyc;

  input_debouncer_if #(.DIGITS(DIGITS)) bus ();

  input_debouncer #(
    .DIGITS(DIGITS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  int              run  [DIGITS];
  bit              lvl  [DIGITS];
  int              held [DIGITS];
  logic [DIGITS-1:0] e_lvl, e_rise, e_fall;
  logic [DIGITS-1:0] v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      run[i] = 0; lvl[i] = 0; held[i] = 0;
    end
    e_lvl = '0; e_rise = '0; e_fall = '0;
  endtask

  task automatic model_edge(input logic [DIGITS-1:0] s);
    for (int i = 0; i < DIGITS; i++) begin
      bit r, f;
      r = 0; f = 0;
      if (s[i] != lvl[i]) begin
        run[i]++;
        if (run[i] == DC) begin
          lvl[i] = s[i]; run[i] = 0; held[i] = 0;
          if (s[i]) r = 1; else f = 1;
        end
      end else begin
        run[i] = 0;
      end
`ifdef DEBOUNCER_AUTOREPEAT_EN
      // repeats at RD, RD+RP, RD+2RP ... edges after the rise
      if (lvl[i] && !r) begin
        held[i]++;
        if (held[i] >= RD && (held[i] - RD) % RP == 0) r = 1;
      end
`endif
      if (!lvl[i]) held[i] = 0;
      e_lvl[i] = lvl[i]; e_rise[i] = r; e_fall[i] = f;
    end
  endtask

  task automatic check_outs();
    chk("level", 32'(bus.level_out), 32'(e_lvl));
    chk("rise",  32'(bus.rise_pulse), 32'(e_rise));
    chk("fall",  32'(bus.fall_pulse), 32'(e_fall));
    chk("excl",  32'(bus.rise_pulse & bus.fall_pulse), 32'd0);
  endtask

  // apply one input vector across one clock edge, then check
  task automatic step(input logic [DIGITS-1:0] s);
    bus.sync_in = s;
    @(posedge clk);
    cyc++;
    model_edge(s);
    #1;
    check_outs();
  endtask

  task automatic steps(input logic [DIGITS-1:0] s, input int n);
    for (int k = 0; k < n; k++) step(s);
  endtask

  // async reset held for n edges; outputs must sit at zero throughout
  task automatic pulse_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outs();
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      check_outs();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    reset_n = 1'b0;
    bus.sync_in = '1;
    model_reset();
    // reset with all inputs high, then release: rise on 4th edge
    repeat (2) @(posedge clk);
    #1;
    pulse_reset(3);
    steps('1, 6);
    chk("rst_rel_lvl", 32'(bus.level_out), 32'h3F);
    steps('0, 6);
    // glitch rejection then genuine rise on bit0
    v = '0;
    steps(6'h01, 3); steps(6'h00, 4);
    steps(6'h01, 4);
    chk("glitch_ok", 32'(bus.level_out), 32'h01);
    steps(6'h00, 6);
    // bounce on bit2: 1,1,0,1,1,1,1 then 0 x4
    steps(6'h04, 2); steps(6'h00, 1); steps(6'h04, 4);
    steps(6'h00, 5);
    // independence: bits 1 and 4 toggled two cycles apart
    steps(6'h02, 2); steps(6'h12, 6);
    steps(6'h10, 2); steps(6'h00, 6);
    // reset mid-count on bit3
    steps(6'h08, 2);
    pulse_reset(1);
    steps(6'h08, 6);
    // long hold on bit5 for auto-repeat, then release
    steps(6'h28, 45);
    steps(6'h08, 8);
    steps(6'h00, 6);
    // random fast bouncing
    v = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < DIGITS; i++)
        if ($urandom_range(7) == 0) v[i] = ~v[i];
      step(v);
    end
    // random slow toggling (exercises long holds)
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < DIGITS; i++)
        if ($urandom_range(59) == 0) v[i] = ~v[i];
      step(v);
      if (k == 700) pulse_reset(2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Per-bit debouncer and edge detector that consumes the DIGITS-wide synchronized button/switch vector produced by the two-flop input synchronizer stage.
- Emits clean debounced levels plus single-cycle rise/fall pulses that drive the counter control logic (increment, decrement, load, mode).
- Each bit is fully independent; no cross-bit interaction.

Parameters:
- DIGITS, 6: number of independent input bits.
- DEBOUNCE_CYCLES, 16: consecutive differing samples required to accept a level change; legal range ≥2.
- REPEAT_DELAY, 4096: cycles from debounced rise to first auto-repeat pulse (feature only); must be > REPEAT_PERIOD.
- REPEAT_PERIOD, 512: cycles between subsequent auto-repeat pulses (feature only); ≥1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sync_in  input  DIGITS  synchronized raw inputs; already in the clk domain, no further synchronization here.
- level_out  output  DIGITS  debounced level per bit.
- rise_pulse  output  DIGITS  one-cycle pulse on debounced 0→1 (and on auto-repeat when enabled).
- fall_pulse  output  DIGITS  one-cycle pulse on debounced 1→0.

Behaviour:
- Reset (reset_n low, asynchronous assert): level_out=0, rise_pulse=0, fall_pulse=0, all internal counters=0. Outputs stay at these values while reset_n is low.
- Per-bit counter cnt[i], width $clog2(DEBOUNCE_CYCLES).
- Each clk edge, per bit:
  - sync_in[i]==level_out[i] → cnt[i]<=0, no pulse.
  - mismatch and cnt[i]<DEBOUNCE_CYCLES-1 → cnt[i]<=cnt[i]+1.
  - mismatch and cnt[i]==DEBOUNCE_CYCLES-1 → level_out[i] toggles, cnt[i]<=0, matching pulse asserted.
- Latency: a level change is accepted on the DEBOUNCE_CYCLES-th consecutive edge sampling the new value. level_out and its pulse change on the same edge.
- Glitches: any mismatch run shorter than DEBOUNCE_CYCLES is discarded with no output change. A single matching sample restarts the count from 0.
- Pulses: registered outputs, high for exactly one cycle, low otherwise. rise_pulse and fall_pulse are never high together on the same bit.
- Minimum spacing between consecutive accepted edges on one bit: DEBOUNCE_CYCLES cycles.
- Reset release with sync_in[i] already high: after DEBOUNCE_CYCLES edges, level_out[i] rises and rise_pulse[i] fires once. This is required behaviour.
- Reset asserted mid-count: all progress is discarded; counting restarts from 0 after release.
- Counter arithmetic never wraps; cnt is saturated by construction at DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: DEBOUNCER_AUTOREPEAT_EN.
- Defined:
  - Per-bit hold counter, width $clog2(REPEAT_DELAY+1), cleared on reset and whenever level_out[i] is 0.
  - Counting starts the edge after a debounced rise, incrementing while level_out[i]=1.
  - On reaching REPEAT_DELAY: rise_pulse[i] fires for one cycle and the counter reloads REPEAT_DELAY-REPEAT_PERIOD.
  - Result: repeat pulses at REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, … cycles after the rise edge.
  - A debounced fall stops repeats immediately; fall_pulse is unaffected.
- Undefined: no hold counters are instantiated; rise_pulse fires only on debounced 0→1. Ports are identical in both builds.

Test Plan (DIGITS=6, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset: hold reset_n=0 with sync_in=6'h3F → all outputs 0. Release → level_out=6'h3F at the 4th edge, rise_pulse=6'h3F for exactly that one cycle.
- Glitch rejection: bit0 high for 3 cycles then low → level_out[0] stays 0, no pulses. Bit0 high for 4 cycles → rise_pulse[0] on the 4th edge.
- Bounce: bit2 pattern 1,1,0,1,1,1,1 → count restarts at the 0 sample; rise on the 4th consecutive 1 (7th edge). Then 0 for 4 cycles → fall_pulse[2] once, level_out[2]=0.
- Independence: bits 1 and 4 toggled 2 cycles apart → each pulse appears exactly 4 edges after its own change; other bits stay quiet.
- Reset mid-count: bit3 high for 2 cycles, assert reset_n=0 for 1 cycle, release with bit3 still high → rise at the 4th post-release edge, not earlier.
- Auto-repeat (macro defined): bit5 held high → rise pulses at rise edge +0, +20, +28, +36. Drop bit5 → fall_pulse after 4 cycles, no further rises. With macro undefined → only the +0 pulse.
